pipeline_stage_skid: RTL and testbench

- Parametrised elastic pipeline-stage register, the successor to the fixed-field stage registers between IF/ID/EX/MEM/WB.
- Carries a control vector and a data payload, and adds a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, synchronous flush (bubble insertion) and a saturating stall counter.
- Each stage boundary of the pipelined CPU instantiates one.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipeline_stage_skid_stage_entry.sv | 27 ++
 rtl/pipeline_stage_skid.sv | 133 +++++++++++++
 tb/tb_pipeline_stage_skid.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline-stage registers.
//   stage_state_e : occupancy state of a stage (encoding equals entry count)
//   OCC_W         : width of the occupancy output
//   *_CTRL_W / *_DATA_W : default control/payload widths per stage boundary
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  localparam int OCC_W = 2;

  localparam int IF_ID_CTRL_W  = 4;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 15;
  localparam int ID_EX_DATA_W  = 110;
  localparam int EX_MEM_CTRL_W = 8;
  localparam int EX_MEM_DATA_W = 72;
  localparam int MEM_WB_CTRL_W = 3;
  localparam int MEM_WB_DATA_W = 38;

endpackage

// File: rtl/pipeline_stage_skid_stage_entry.sv
// One held entry of a pipeline stage: a load-enabled register, cleared to 0
// by the asynchronous active-low reset.
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   load_i : capture d_i at the next rising edge
//   d_i    : entry to capture {ctrl, data}
//   q_o    : held entry
module stage_entry #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      q_q <= '0;
    else if (load_i) q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipeline_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
// Carries a control vector and a payload across a valid/ready boundary at
// full throughput, supports synchronous flush and counts stall cycles.
//   clk, reset          : clock (rising) and async active-low reset
//   flush               : drop held entries and any same-cycle input
//   in_valid/in_ready   : upstream handshake; in_ready is registered
//   in_ctrl/in_data     : upstream entry
//   out_valid/out_ready : downstream handshake
//   out_ctrl/out_data   : downstream entry (ctrl forced to CTRL_BUBBLE if idle)
//   occupancy           : held entries 0..2
//   stall_cnt           : saturating count of out_valid & !out_ready cycles
//
// state | meaning
// EMPTY | no entry held, accepts input
// ONE   | main entry valid, accepts input
// TWO   | main and skid valid, input blocked
module pipeline_stage_skid
  import pipe_pkg::*;
#(
  parameter int                CTRL_W      = 15,
  parameter int                DATA_W      = 110,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter int                CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int ENT_W = CTRL_W + DATA_W;

  stage_state_e     state_q, state_d;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             main_load, skid_load;
  logic [ENT_W-1:0] main_d, main_q, skid_q;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = {in_ctrl, in_data};
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_load = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_load = 1'b1;
        end else if (in_fire) begin
          skid_load = 1'b1;
          state_d   = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_d    = skid_q;
          main_load = 1'b1;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d   = EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // in_ready is derived from the next state so it is a pure flop output;
  // it resets to 0 and so also blocks the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      cnt_q      <= cnt_d;
    end
  end

  stage_entry #(.W(ENT_W)) u_main (
    .clk    (clk),
    .reset  (reset),
    .load_i (main_load),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  stage_entry #(.W(ENT_W)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .load_i (skid_load),
    .d_i    ({in_ctrl, in_data}),
    .q_o    (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_data  = main_q[DATA_W-1:0];
  assign out_ctrl  = out_valid ? main_q[ENT_W-1:DATA_W] : CTRL_BUBBLE;
  assign occupancy = state_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_stage_skid.sv
module tb_pipeline_stage_skid;

  localparam int CTRL_W = 15;
  localparam int DATA_W = 110;
  localparam int CNT_W  = 4;
  localparam int ENT_W  = CTRL_W + DATA_W;
  localparam logic [CTRL_W-1:0] BUBBLE = '0;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [ENT_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_stage_skid #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE(BUBBLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  function automatic logic [ENT_W-1:0] mk(input logic [DATA_W-1:0] d);
    logic [CTRL_W-1:0] c;
    c = d[CTRL_W-1:0] ^ 15'h0F0F;
    return {c, d};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [DATA_W-1:0] d);
    logic [ENT_W-1:0] e;
    e = mk(d);
    in_valid = v;
    in_ctrl  = e[ENT_W-1:DATA_W];
    in_data  = d;
  endtask

  // Sample point: record accepted stimulus into the scoreboard.
  task automatic sample();
    @(negedge clk);
    if (flush) exp_q.delete();
    else if (reset && in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every downstream transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got %0h expected none", out_data);
      end else begin
        check("out_entry", {out_ctrl, out_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, '0);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_out_ctrl", out_ctrl, BUBBLE);
    check("rst_out_data", out_data, 0);
    adv();
    reset = 1'b1;
    adv();

    // stream 1..4 with no backpressure
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b1, DATA_W'(i));
      sample();
      if (i == 1) check("stream_first_empty", out_valid, 0);
      else begin
        check("stream_valid", out_valid, 1);
        check("stream_data", out_data, i - 1);
        check("stream_occ", occupancy, 1);
      end
      adv();
    end
    set_in(1'b0, '0);
    sample();
    check("stream_last", out_data, 4);
    check("stream_occ_last", occupancy, 1);
    adv();
    sample();
    check("stream_done_valid", out_valid, 0);
    check("stream_stall", stall_cnt, 0);
    adv();

    // backpressure fill
    out_ready = 1'b0;
    set_in(1'b1, 'h11);
    sample();
    check("bp_occ0", occupancy, 0);
    adv();
    set_in(1'b1, 'h22);
    sample();
    check("bp_occ1", occupancy, 1);
    check("bp_data_a", out_data, 'h11);
    check("bp_stall0", stall_cnt, 0);
    adv();
    set_in(1'b1, 'h44);
    sample();
    check("bp_occ2", occupancy, 2);
    check("bp_in_ready", in_ready, 0);
    check("bp_stall1", stall_cnt, 1);
    check("bp_hold_a", out_data, 'h11);
    adv();
    set_in(1'b0, '0);
    sample();
    check("bp_stall2", stall_cnt, 2);
    adv();
    sample();
    check("bp_stall3", stall_cnt, 3);
    adv();

    // drain from full
    out_ready = 1'b1;
    sample();
    check("drain_occ2", occupancy, 2);
    check("drain_a", out_data, 'h11);
    adv();
    sample();
    check("drain_occ1", occupancy, 1);
    check("drain_b", out_data, 'h22);
    adv();
    sample();
    check("drain_occ0", occupancy, 0);
    check("drain_bubble", out_ctrl, BUBBLE);
    check("drain_stall", stall_cnt, 4);
    adv();

    // flush in TWO with simultaneous input
    out_ready = 1'b0;
    set_in(1'b1, 'h55);
    sample(); adv();
    set_in(1'b1, 'h66);
    sample(); adv();
    flush = 1'b1;
    set_in(1'b1, 'h33);
    sample();
    check("flush_cur_valid", out_valid, 1);
    adv();
    flush = 1'b0; out_ready = 1'b1;
    set_in(1'b0, '0);
    sample();
    check("flush_occ", occupancy, 0);
    check("flush_valid", out_valid, 0);
    check("flush_bubble", out_ctrl, BUBBLE);
    check("flush_in_ready", in_ready, 1);
    adv();

    // flush in ONE while the input actually fires
    out_ready = 1'b0;
    set_in(1'b1, 'h77);
    sample(); adv();
    flush = 1'b1;
    set_in(1'b1, 'h33);
    sample();
    check("flush1_in_ready", in_ready, 1);
    adv();
    flush = 1'b0; out_ready = 1'b1;
    set_in(1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      sample();
      check("flush1_no_33", out_valid, 0);
      adv();
    end
    check("flush_keeps_stall", stall_cnt, 7);

    // stall counter saturation (starts at 7)
    out_ready = 1'b0;
    set_in(1'b1, 'h88);
    sample(); adv();
    set_in(1'b0, '0);
    for (int k = 0; k < 20; k++) begin
      sample();
      check("sat_cnt", stall_cnt, (7 + k > 15) ? 15 : 7 + k);
      adv();
    end
    sample();
    check("sat_hold", stall_cnt, 15);
    adv();

    // async reset in TWO, between clock edges
    set_in(1'b1, 'h99);
    sample(); adv();
    set_in(1'b0, '0);
    sample();
    check("pre_rst_occ", occupancy, 2);
    adv();
    #3 reset = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_occ", occupancy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_stall", stall_cnt, 0);
    exp_q.delete();
    adv();
    sample();
    check("arst_hold_ready", in_ready, 0);
    adv();
    reset = 1'b1;
    out_ready = 1'b1;
    set_in(1'b1, 'hAB);
    sample();
    check("rel_in_ready", in_ready, 0);
    adv();
    sample();
    check("rel_in_ready1", in_ready, 1);
    adv();
    set_in(1'b0, '0);
    sample();
    check("rel_data", out_data, 'hAB);
    adv();
    sample();
    check("end_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
